// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer: gathers N consecutive FIR samples per bank and presents
// each full bank as one flat word to the FFT stage with a valid/ack handshake.
module fir_frame_buffer #(
  parameter int DW = 16,
  parameter int N  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fir_valid,
  input  logic [DW-1:0]   fir_d,
  input  logic            frame_ack,
  output logic            frame_valid,
  output logic [N*DW-1:0] frame_data,
  output logic [4:0]      fill_level,
  output logic [7:0]      frame_cnt,
  output logic            overrun
);

  localparam int AW = $clog2(N);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            overrun_q, overrun_d;
  logic [N*DW-1:0] bank_q [2];

  logic            wr_en_s;
  logic            last_s;
  logic            ack_s;

  // Next-state logic. Completion and ack always target different banks, because
  // a write needs its bank empty while an ack needs its bank full.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;

    wr_en_s = fir_valid & ~full_q[wr_bank_q];
    last_s  = wr_en_s & (wr_ptr_q == AW'(N - 1));
    ack_s   = frame_ack & full_q[rd_bank_q];

    if (ack_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end

    if (last_s) begin
      wr_ptr_d          = '0;
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      frame_cnt_d       = frame_cnt_q + 8'd1;
    end else if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Sample arrives at a full bank: dropped, flagged until reset.
    if (fir_valid && full_q[wr_bank_q]) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      frame_cnt_q <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Sample storage, written in arrival order into the active bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else if (wr_en_s) begin
      bank_q[wr_bank_q][int'(wr_ptr_q)*DW +: DW] <= fir_d;
    end
  end

  assign frame_valid = full_q[rd_bank_q];
  assign frame_data  = bank_q[rd_bank_q];
  assign fill_level  = 5'(wr_ptr_q);
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fir_frame_buffer.sv
// Directed bench for fir_frame_buffer: stimulus pushes completed frames into a
// queue; a negedge monitor pops one entry per newly presented frame.
module tb_fir_frame_buffer;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int FW = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          fir_valid;
  logic [DW-1:0] fir_d;
  logic          frame_ack;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic [4:0]    fill_level;
  logic [7:0]    frame_cnt;
  logic          overrun;

  int n_checks = 0;
  int n_pass   = 0;

  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] model_frame;
  int            model_idx;

  logic          mon_prev_valid = 1'b0;
  logic          mon_took_ack   = 1'b0;
  logic [FW-1:0] mon_cur        = '0;

  fir_frame_buffer #(.DW(DW), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fir_valid),
    .fir_d       (fir_d),
    .frame_ack   (frame_ack),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .fill_level  (fill_level),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: drive inputs, wait for the edge, then update the bench model.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic acc, input logic ack);
    fir_valid = v;
    fir_d     = d;
    frame_ack = ack;
    @(posedge clk);
    #1;
    fir_valid = 1'b0;
    frame_ack = 1'b0;
    if (v && acc) begin
      model_frame[model_idx*DW +: DW] = d;
      model_idx++;
      if (model_idx == N) begin
        exp_q.push_back(model_frame);
        model_idx = 0;
      end
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    model_idx   = 0;
    model_frame = '0;
  endtask

  // Monitor: a frame is new when valid rises or the previous cycle took an ack.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        if (!mon_prev_valid || mon_took_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got frame %0h expected none", frame_data);
          end else begin
            mon_cur = exp_q.pop_front();
            check("sb_frame", frame_data, mon_cur);
          end
        end else begin
          check("sb_hold", frame_data, mon_cur);
        end
      end
      mon_prev_valid = (frame_valid === 1'b1);
      mon_took_ack   = (frame_valid === 1'b1) && (frame_ack === 1'b1);
    end
  end

  initial begin
    rst       = 1'b0;
    fir_valid = 1'b0;
    fir_d     = '0;
    frame_ack = 1'b0;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", frame_valid, 0);
    check("rst_data", frame_data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: samples 1..16, valid on the 16th edge
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) check("t1_pre_valid", frame_valid, 0);
      cyc(1'b1, DW'(k), 1'b1, 1'b0);
    end
    check("t1_valid", frame_valid, 1);
    check("t1_first", frame_data[15:0], 16'd1);
    check("t1_last", frame_data[255:240], 16'd16);
    check("t1_cnt", frame_cnt, 1);

    // T2: fill second bank while first is held, then overrun
    for (int k = 17; k <= 32; k++) cyc(1'b1, DW'(k), 1'b1, 1'b0);
    cyc(1'b1, 16'd33, 1'b0, 1'b0);
    check("t2_ovr", overrun, 1);
    check("t2_fill", fill_level, 0);
    check("t2_cnt", frame_cnt, 2);
    check("t2_held", frame_data[15:0], 16'd1);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    check("t2_next_valid", frame_valid, 1);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    check("t2_drained", frame_valid, 0);

    // T3: ack on the same edge that completes the second bank
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_flush();
    @(posedge clk);
    #1;
    check("t3_ovr_clr", overrun, 0);
    for (int k = 0; k < 16; k++) cyc(1'b1, 16'h0100 + DW'(k), 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) cyc(1'b1, 16'h0200 + DW'(k), 1'b1, (k == 15) ? 1'b1 : 1'b0);
    check("t3_no_gap", frame_valid, 1);
    check("t3_data", frame_data[15:0], 16'h0200);
    check("t3_ovr", overrun, 0);
    check("t3_cnt", frame_cnt, 2);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    check("t3_drained", frame_valid, 0);

    // T4: alternating valid, extreme signed values
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t4_pre_valid", frame_valid, 0);
      cyc(1'b1, (i % 2 == 1) ? 16'h7FFF : 16'h8000, 1'b1, 1'b0);
      if (i < 15) cyc(1'b0, 16'd0, 1'b0, 1'b0);
    end
    check("t4_valid", frame_valid, 1);
    check("t4_cnt", frame_cnt, 3);
    check("t4_s0", frame_data[15:0], 16'h8000);
    check("t4_s1", frame_data[31:16], 16'h7FFF);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);

    // T5: asynchronous reset mid-frame, between edges
    for (int k = 0; k < 7; k++) cyc(1'b1, 16'h0500 + DW'(k), 1'b1, 1'b0);
    check("t5_fill7", fill_level, 7);
    #3;
    rst = 1'b0;
    #1;
    check("t5_valid", frame_valid, 0);
    check("t5_data", frame_data, 0);
    check("t5_fill", fill_level, 0);
    check("t5_cnt", frame_cnt, 0);
    check("t5_ovr", overrun, 0);
    model_flush();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T6: ack with nothing presented is ignored; next frame lands in bank 0
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    check("t6_valid0", frame_valid, 0);
    check("t6_fill0", fill_level, 0);
    for (int k = 0; k < 16; k++) cyc(1'b1, 16'h0600 + DW'(k), 1'b1, 1'b0);
    check("t6_rd_bank", frame_valid, 1);
    check("t6_cnt", frame_cnt, 1);
    check("t6_data", frame_data[15:0], 16'h0600);
    cyc(1'b0, 16'd0, 1'b0, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0);
    check("end_valid", frame_valid, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
